// File: rtl/rx_mii_frame_receiver_if.sv
// MII receive bundle plus MAC-side frame buffer access for rx_mii_frame_receiver.
// master: PHY/MAC side driving the receiver; slave: the receiver itself.
interface rx_mii_frame_receiver_if #(
  parameter int unsigned BUF_AW = 4
);
  logic              rx_clk;
  logic              rx_dv;
  logic              rx_er;
  logic [3:0]        rx_data;
  logic [BUF_AW-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              rd_done;
  logic              frame_valid;
  logic [BUF_AW:0]   frame_len;
  logic              crc_ok;
  logic [2:0]        err_flags;
  logic [7:0]        drop_count;

  modport master (
    output rx_clk, rx_dv, rx_er, rx_data, rd_addr, rd_done,
    input  rd_data, frame_valid, frame_len, crc_ok, err_flags, drop_count
  );

  modport slave (
    input  rx_clk, rx_dv, rx_er, rx_data, rd_addr, rd_done,
    output rd_data, frame_valid, frame_len, crc_ok, err_flags, drop_count
  );
endinterface

// File: rtl/rx_mii_frame_receiver.sv
// MII receive front end: oversamples the PHY nibble stream in the clk domain, strips
// preamble/SFD, buffers one frame, checks its FCS and holds it for the MAC until rd_done.
// Optional destination-address filter: define RX_ADDR_FILTER_EN (adds parameter MY_MAC).
module rx_mii_frame_receiver #(
  parameter int unsigned BUF_AW  = 4,
  parameter int unsigned MIN_LEN = 4
`ifdef RX_ADDR_FILTER_EN
  ,
  parameter logic [47:0] MY_MAC  = 48'h0
`endif
) (
  input logic                      clk,
  input logic                      reset_n,
  rx_mii_frame_receiver_if.slave   bus
);

  localparam int unsigned DEPTH   = 2 ** BUF_AW;
  localparam logic [31:0] CRC_RES = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    StIdle, StPreamble, StData, StCheck, StHold, StDrop, StDiscard
  } state_e;

  state_e            state_q;
  logic [2:0]        clk_sync_q;
  logic [1:0]        dv_sync_q, er_sync_q;
  logic [3:0]        data_s1_q, data_s2_q;
  logic              samp, dv, er;

  logic [31:0]       crc_q, crc_next;
  logic              phase_q;
  logic [3:0]        low_q;
  logic [BUF_AW:0]   count_q;
  logic              ovf_q, align_q, phy_q, release_q;
  logic              frame_valid_q, crc_ok_q;
  logic [BUF_AW:0]   frame_len_q;
  logic [2:0]        err_q;
  logic [7:0]        drop_q;

  logic [7:0]        mem [DEPTH];
  logic [7:0]        rd_data_q;
  logic [7:0]        rx_byte;
  logic              wr_en;
  logic [BUF_AW-1:0] wr_addr;

`ifdef RX_ADDR_FILTER_EN
  logic              hit_my_q, hit_bc_q;
  logic [7:0]        my_byte;
`endif

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Two-flop synchronizers; third rx_clk flop gives the rising-edge sample strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= '0;
      dv_sync_q  <= '0;
      er_sync_q  <= '0;
      data_s1_q  <= '0;
      data_s2_q  <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], bus.rx_clk};
      dv_sync_q  <= {dv_sync_q[0], bus.rx_dv};
      er_sync_q  <= {er_sync_q[0], bus.rx_er};
      data_s1_q  <= bus.rx_data;
      data_s2_q  <= data_s1_q;
    end
  end

  assign samp = clk_sync_q[1] & ~clk_sync_q[2];
  assign dv   = dv_sync_q[1];
  assign er   = er_sync_q[1];

  // Byte assembly and buffer write strobe; a byte past the buffer end is never written.
  always_comb begin
    rx_byte  = {data_s2_q, low_q};
    wr_en    = (state_q == StData) & samp & dv & phase_q & ~count_q[BUF_AW];
    wr_addr  = count_q[BUF_AW-1:0];
    crc_next = crc_step(crc_q, rx_byte);
  end

`ifdef RX_ADDR_FILTER_EN
  // Expected destination byte for the current position, first byte on the wire is MSB.
  always_comb begin
    my_byte = 8'h00;
    case (count_q[2:0])
      3'd0:    my_byte = MY_MAC[47:40];
      3'd1:    my_byte = MY_MAC[39:32];
      3'd2:    my_byte = MY_MAC[31:24];
      3'd3:    my_byte = MY_MAC[23:16];
      3'd4:    my_byte = MY_MAC[15:8];
      3'd5:    my_byte = MY_MAC[7:0];
      default: my_byte = 8'h00;
    endcase
  end
`endif

  // Frame buffer storage, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= rx_byte;
  end

  // Registered read port, always enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data_q <= '0;
    else          rd_data_q <= mem[bus.rd_addr];
  end

  // Receive FSM with registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      crc_q         <= 32'hFFFFFFFF;
      phase_q       <= 1'b0;
      low_q         <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      align_q       <= 1'b0;
      phy_q         <= 1'b0;
      release_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      crc_ok_q      <= 1'b0;
      frame_len_q   <= '0;
      err_q         <= '0;
      drop_q        <= '0;
`ifdef RX_ADDR_FILTER_EN
      hit_my_q      <= 1'b0;
      hit_bc_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (samp && dv) state_q <= StPreamble;
        end
        StPreamble: begin
          if (samp) begin
            if (!dv) begin
              state_q <= StIdle;
            end else if (data_s2_q == 4'hD) begin
              state_q <= StData;
              phase_q <= 1'b0;
              count_q <= '0;
              crc_q   <= 32'hFFFFFFFF;
              ovf_q   <= 1'b0;
              align_q <= 1'b0;
              phy_q   <= 1'b0;
`ifdef RX_ADDR_FILTER_EN
              hit_my_q <= 1'b1;
              hit_bc_q <= 1'b1;
`endif
            end
          end
        end
        StData: begin
          if (samp) begin
            if (!dv) begin
              align_q <= phase_q;
              phase_q <= 1'b0;
              state_q <= StCheck;
            end else begin
              if (er) phy_q <= 1'b1;
              if (!phase_q) begin
                low_q   <= data_s2_q;
                phase_q <= 1'b1;
              end else begin
                phase_q <= 1'b0;
                // Count saturates at DEPTH; further bytes only flag overflow.
                if (count_q[BUF_AW]) begin
                  ovf_q <= 1'b1;
                end else begin
                  count_q <= count_q + {{BUF_AW{1'b0}}, 1'b1};
                  crc_q   <= crc_next;
                end
`ifdef RX_ADDR_FILTER_EN
                if (32'(count_q) < 6) begin
                  hit_my_q <= hit_my_q & (rx_byte == my_byte);
                  hit_bc_q <= hit_bc_q & (rx_byte == 8'hFF);
                  if ((32'(count_q) == 5) && !(hit_my_q && (rx_byte == my_byte)) &&
                      !(hit_bc_q && (rx_byte == 8'hFF))) begin
                    state_q <= StDiscard;
                  end
                end
`endif
              end
            end
          end
        end
        StCheck: begin
          crc_ok_q      <= (crc_q == CRC_RES) & ~ovf_q & ~phy_q & ~align_q &
                           (32'(count_q) >= MIN_LEN);
          err_q         <= {ovf_q, align_q, phy_q};
          frame_len_q   <= count_q;
          frame_valid_q <= 1'b1;
          release_q     <= 1'b0;
          state_q       <= StHold;
        end
        StHold: begin
          if (bus.rd_done) begin
            frame_valid_q <= 1'b0;
            crc_ok_q      <= 1'b0;
            err_q         <= '0;
            state_q       <= StIdle;
          end else if (samp && dv) begin
            state_q <= StDrop;
          end
        end
        StDrop: begin
          if (bus.rd_done) begin
            frame_valid_q <= 1'b0;
            crc_ok_q      <= 1'b0;
            err_q         <= '0;
          end
          // A release seen mid-drop is remembered so the drop ends in IDLE.
          if (samp && !dv) begin
            if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            state_q   <= (release_q || bus.rd_done) ? StIdle : StHold;
            release_q <= 1'b0;
          end else if (bus.rd_done) begin
            release_q <= 1'b1;
          end
        end
        StDiscard: begin
          if (samp && !dv) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.crc_ok      = crc_ok_q;
  assign bus.err_flags   = err_q;
  assign bus.drop_count  = drop_q;

endmodule

// File: tb/tb_rx_mii_frame_receiver.sv
// Scoreboard bench for rx_mii_frame_receiver: stimulus pushes expected frame results,
// a monitor pops and compares each presented frame, then releases it with rd_done.
module tb_rx_mii_frame_receiver;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rx_mii_frame_receiver_if #(.BUF_AW(4)) bus ();

  rx_mii_frame_receiver #(.BUF_AW(4), .MIN_LEN(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int               len;
    bit               crc_ok;
    logic [2:0]       flags;
    logic [15:0][7:0] data;
    int               nchk;
    bit               hold;
    int               exp_drop;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   frames_done = 0;
  bit   release_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference Ethernet FCS: reflected CRC-32, init all ones, inverted, sent LSB byte first.
  function automatic bq_t with_fcs(input bq_t p);
    logic [31:0] c;
    bq_t r;
    c = 32'hFFFFFFFF;
    r = p;
    foreach (p[i]) begin
      c = c ^ {24'h0, p[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    r.push_back(c[7:0]);
    r.push_back(c[15:8]);
    r.push_back(c[23:16]);
    r.push_back(c[31:24]);
    return r;
  endfunction

  function automatic exp_t mk_exp(input bq_t b, input int len, input bit ok,
                                  input logic [2:0] fl, input bit hold, input int drop);
    exp_t e;
    e.len      = len;
    e.crc_ok   = ok;
    e.flags    = fl;
    e.hold     = hold;
    e.exp_drop = drop;
    e.data     = '0;
    e.nchk     = (len > 16) ? 16 : len;
    for (int i = 0; i < e.nchk; i++) e.data[i] = b[i];
    return e;
  endfunction

  // One rx_clk period (80 ns): inputs change while rx_clk is low.
  task automatic nib(input logic dv, input logic er, input logic [3:0] d);
    bus.rx_dv   = dv;
    bus.rx_er   = er;
    bus.rx_data = d;
    #40 bus.rx_clk = 1'b1;
    #40 bus.rx_clk = 1'b0;
  endtask

  task automatic send_frame(input bq_t b, input int extra_nib, input int er_byte,
                            input bit tail);
    for (int i = 0; i < 15; i++) nib(1'b1, 1'b0, 4'h5);
    nib(1'b1, 1'b0, 4'hD);
    foreach (b[i]) begin
      nib(1'b1, (i == er_byte), b[i][3:0]);
      nib(1'b1, 1'b0, b[i][7:4]);
    end
    for (int i = 0; i < extra_nib; i++) nib(1'b1, 1'b0, 4'hA);
    if (tail) for (int i = 0; i < 4; i++) nib(1'b0, 1'b0, 4'h0);
  endtask

  task automatic read_byte(input int a, output logic [7:0] d);
    @(negedge clk) bus.rd_addr = 4'(a);
    @(negedge clk) d = bus.rd_data;
  endtask

  task automatic wait_frames(input int n);
    for (int t = 0; t < 20000 && frames_done < n; t++) @(negedge clk);
    check("frames_done", frames_done, n);
  endtask

  // Monitor: compare every presented frame against the scoreboard head.
  initial begin : monitor
    exp_t e;
    logic [7:0] d;
    int t;
    bus.rd_addr = '0;
    bus.rd_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.frame_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_frame: got frame_len %0d, expected no frame", bus.frame_len);
        end else begin
          e = sb.pop_front();
          check("frame_len", 32'(bus.frame_len), e.len);
          check("crc_ok", 32'(bus.crc_ok), 32'(e.crc_ok));
          check("err_flags", 32'(bus.err_flags), 32'(e.flags));
          for (int i = 0; i < e.nchk; i++) begin
            read_byte(i, d);
            check($sformatf("rd_data[%0d]", i), 32'(d), 32'(e.data[i]));
          end
          if (e.hold) begin
            for (t = 0; t < 20000 && !release_req; t++) @(negedge clk);
            check("release_req_seen", 32'(release_req), 1);
            release_req = 1'b0;
            for (int i = 0; i < e.nchk; i++) begin
              read_byte(i, d);
              check($sformatf("held_data[%0d]", i), 32'(d), 32'(e.data[i]));
            end
            check("drop_count_held", 32'(bus.drop_count), e.exp_drop);
            check("frame_valid_held", 32'(bus.frame_valid), 1);
          end
        end
        @(negedge clk) bus.rd_done = 1'b1;
        @(negedge clk) bus.rd_done = 1'b0;
        check("frame_valid_release", 32'(bus.frame_valid), 0);
        frames_done++;
      end
    end
  end

  // Directed stimulus.
  initial begin : stim
    bq_t f, p, e0;
    bus.rx_clk  = 1'b0;
    bus.rx_dv   = 1'b0;
    bus.rx_er   = 1'b0;
    bus.rx_data = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_frame_valid", 32'(bus.frame_valid), 0);
    check("rst_drop_count", 32'(bus.drop_count), 0);
    check("rst_crc_ok", 32'(bus.crc_ok), 0);
    check("rst_err_flags", 32'(bus.err_flags), 0);
    check("rst_frame_len", 32'(bus.frame_len), 0);
    check("rst_rd_data", 32'(bus.rd_data), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good frame 01 02 03 04 + FCS.
    f = with_fcs('{8'h01, 8'h02, 8'h03, 8'h04});
    sb.push_back(mk_exp(f, 8, 1'b1, 3'b000, 1'b0, 0));
    send_frame(f, 0, -1, 1'b1);
    wait_frames(1);

    // Last FCS byte corrupted.
    f[7] = f[7] ^ 8'h01;
    sb.push_back(mk_exp(f, 8, 1'b0, 3'b000, 1'b0, 0));
    send_frame(f, 0, -1, 1'b1);
    wait_frames(2);

    // 20 bytes into a 16-byte buffer.
    p = {};
    for (int i = 0; i < 20; i++) p.push_back(8'(8'h10 + i));
    sb.push_back(mk_exp(p, 16, 1'b0, 3'b100, 1'b0, 0));
    send_frame(p, 0, -1, 1'b1);
    wait_frames(3);

    // Valid frame plus one stray nibble (17 nibbles).
    f = with_fcs('{8'hA1, 8'hB2, 8'hC3, 8'hD4});
    sb.push_back(mk_exp(f, 8, 1'b0, 3'b010, 1'b0, 0));
    send_frame(f, 1, -1, 1'b1);
    wait_frames(4);

    // Minimum length: FCS only (00 00 00 00), exactly MIN_LEN bytes.
    e0 = {};
    f = with_fcs(e0);
    sb.push_back(mk_exp(f, 4, 1'b1, 3'b000, 1'b0, 0));
    send_frame(f, 0, -1, 1'b1);
    wait_frames(5);

    // rx_er on byte 2 of an otherwise valid frame.
    f = with_fcs('{8'h11, 8'h22, 8'h33, 8'h44});
    sb.push_back(mk_exp(f, 8, 1'b0, 3'b001, 1'b0, 0));
    send_frame(f, 0, 2, 1'b1);
    wait_frames(6);

    // Preamble with no SFD: nothing presented, nothing counted.
    for (int i = 0; i < 10; i++) nib(1'b1, 1'b0, 4'h5);
    for (int i = 0; i < 4; i++) nib(1'b0, 1'b0, 4'h0);
    repeat (20) @(negedge clk);
    check("no_sfd_frame_valid", 32'(bus.frame_valid), 0);
    check("no_sfd_frames", frames_done, 6);
    check("no_sfd_drop_count", 32'(bus.drop_count), 0);

    // Frame arriving while one is held gets dropped.
    f = with_fcs('{8'h01, 8'h02, 8'h03, 8'h04});
    sb.push_back(mk_exp(f, 8, 1'b1, 3'b000, 1'b1, 1));
    send_frame(f, 0, -1, 1'b1);
    for (int t = 0; t < 2000 && bus.frame_valid !== 1'b1; t++) @(negedge clk);
    check("held_before_drop", 32'(bus.frame_valid), 1);
    p = with_fcs('{8'h55, 8'h66, 8'h77, 8'h88});
    send_frame(p, 0, -1, 1'b1);
    release_req = 1'b1;
    wait_frames(7);
    check("drop_count_after", 32'(bus.drop_count), 1);
    f = with_fcs('{8'h9A, 8'hBC, 8'hDE, 8'hF0});
    sb.push_back(mk_exp(f, 8, 1'b1, 3'b000, 1'b0, 0));
    send_frame(f, 0, -1, 1'b1);
    wait_frames(8);

    // Reset in the middle of DATA.
    f = '{8'hC0, 8'hFF, 8'hEE};
    send_frame(f, 0, -1, 1'b0);
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk);
    check("midrst_frame_valid", 32'(bus.frame_valid), 0);
    check("midrst_drop_count", 32'(bus.drop_count), 0);
    check("midrst_frame_len", 32'(bus.frame_len), 0);
    check("midrst_err_flags", 32'(bus.err_flags), 0);
    bus.rx_dv = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 3; i++) nib(1'b0, 1'b0, 4'h0);
    f = with_fcs('{8'h21, 8'h43, 8'h65, 8'h87});
    sb.push_back(mk_exp(f, 8, 1'b1, 3'b000, 1'b0, 0));
    send_frame(f, 0, -1, 1'b1);
    wait_frames(9);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
